// File: rtl/detector_pkg.sv
// Shared constants for the detector event path.
// Event word layout and default block count.
package detector_pkg;

  localparam int EVT_BITS = 128;
  localparam int DEF_NBLK = 4;

  localparam int EVT_FRAME_LSB  = 120;
  localparam int EVT_FLAG_LSB   = 112;
  localparam int EVT_ID_LSB     = 96;
  localparam int EVT_ENERGY_LSB = 64;
  localparam int EVT_TIME_LSB   = 0;

  typedef logic [EVT_BITS-1:0] evt_word_t;

endpackage

// File: rtl/detector_event_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from the slot after the
// last grant; pointer moves only on an accepted grant.
module rr_arbiter
  import detector_pkg::*;
#(
  parameter int N = DEF_NBLK,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gnt_idx,
  output logic          valid
);

  logic [PW-1:0] ptr;

  // First requester after the pointer, modulo N.
  always_comb begin
    int idx;
    logic [PW-1:0] j;
    idx     = 0;
    j       = '0;
    grant   = '0;
    gnt_idx = ptr;
    valid   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      j   = PW'(idx);
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        gnt_idx  = j;
      end
    end
  end

  // Pointer starts at N-1 so index 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= PW'(N - 1);
    else if (advance && valid)
      ptr <= gnt_idx;
  end

endmodule

// File: rtl/detector_event_arbiter.sv
// Merges per-block event streams into one registered slot,
// with per-block accept/drop counters and stall OR.
module detector_event_arbiter
  import detector_pkg::*;
#(
  parameter int NBLK      = DEF_NBLK,
  parameter int DATA_BITS = EVT_BITS,
  parameter int CNT_BITS  = 16,
  localparam int SW = $clog2(NBLK)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NBLK-1:0]           in_valid,
  output logic [NBLK-1:0]           in_ready,
  input  logic [NBLK*DATA_BITS-1:0] in_data,
  input  logic [NBLK-1:0]           blk_stall,
  input  logic [NBLK-1:0]           blk_enable,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_BITS-1:0]      out_data,
  output logic [SW-1:0]             out_src,
  output logic                      stall_any,
  input  logic [SW-1:0]             cnt_sel,
  input  logic                      cnt_clear,
  output logic [CNT_BITS-1:0]       cnt_accepted,
  output logic [CNT_BITS-1:0]       cnt_dropped
);

  logic [NBLK-1:0]     grant;
  logic [SW-1:0]       gnt_idx;
  logic                gnt_vld;
  logic                slot_free;
  logic [NBLK-1:0]     acc_inc;
  logic [NBLK-1:0]     drop_inc;
  logic [CNT_BITS-1:0] cnt_acc  [NBLK];
  logic [CNT_BITS-1:0] cnt_drop [NBLK];

  rr_arbiter #(.N(NBLK)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid & blk_enable),
    .advance (slot_free),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .valid   (gnt_vld)
  );

  // Handshakes: granted block when the slot frees; disabled blocks always.
  always_comb begin
    slot_free = ~out_valid | out_ready;
    in_ready  = (grant & {NBLK{slot_free}}) | ~blk_enable;
    acc_inc   = grant & {NBLK{slot_free}};
    drop_inc  = in_valid & ~blk_enable;
  end

  // Output slot: reload on transfer, drain on accept, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (gnt_vld && slot_free) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(gnt_idx)*DATA_BITS +: DATA_BITS];
      out_src   <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Registered stall OR for the time-tag hold line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_any <= 1'b0;
    else
      stall_any <= |blk_stall;
  end

  // Saturating counters; clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBLK; i++) begin
        cnt_acc[i]  <= '0;
        cnt_drop[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBLK; i++) begin
        if (cnt_clear) begin
          cnt_acc[i]  <= '0;
          cnt_drop[i] <= '0;
        end else begin
          if (acc_inc[i] && cnt_acc[i] != '1)
            cnt_acc[i] <= cnt_acc[i] + 1'b1;
          if (drop_inc[i] && cnt_drop[i] != '1)
            cnt_drop[i] <= cnt_drop[i] + 1'b1;
        end
      end
    end
  end

  // Counter readout mux.
  always_comb begin
    cnt_accepted = cnt_acc[cnt_sel];
    cnt_dropped  = cnt_drop[cnt_sel];
  end

endmodule

// File: tb/tb_detector_event_arbiter.sv
// Directed bench for detector_event_arbiter.
// Vector table plus hand sequences for stall, saturation, reset.
module tb_detector_event_arbiter;

  localparam int NB = 4;
  localparam int DB = 128;
  localparam int CB = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [NB-1:0]  in_valid;
  logic [NB-1:0]  in_ready;
  logic [NB*DB-1:0] in_data;
  logic [NB-1:0]  blk_stall;
  logic [NB-1:0]  blk_enable;
  logic           out_valid;
  logic           out_ready;
  logic [DB-1:0]  out_data;
  logic [1:0]     out_src;
  logic           stall_any;
  logic [1:0]     cnt_sel;
  logic           cnt_clear;
  logic [CB-1:0]  cnt_accepted;
  logic [CB-1:0]  cnt_dropped;

  logic [NB-1:0]  s_in_ready;
  logic           s_out_valid;
  logic [DB-1:0]  s_out_data;
  logic [1:0]     s_out_src;
  logic           s_stall_any;
  logic [2:0]     s_cnt_acc;
  logic [2:0]     s_cnt_drop;

  always #5 clk = ~clk;

  detector_event_arbiter #(.NBLK(NB), .DATA_BITS(DB), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .blk_stall(blk_stall), .blk_enable(blk_enable),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .stall_any(stall_any),
    .cnt_sel(cnt_sel), .cnt_clear(cnt_clear),
    .cnt_accepted(cnt_accepted), .cnt_dropped(cnt_dropped)
  );

  // Narrow-counter copy so saturation is reachable in a few beats.
  detector_event_arbiter #(.NBLK(NB), .DATA_BITS(DB), .CNT_BITS(3)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .blk_stall(blk_stall), .blk_enable(blk_enable),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_src(s_out_src), .stall_any(s_stall_any),
    .cnt_sel(cnt_sel), .cnt_clear(cnt_clear),
    .cnt_accepted(s_cnt_acc), .cnt_dropped(s_cnt_drop)
  );

  typedef struct {
    logic [3:0] v;
    logic [3:0] en;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] src;
  } vec_t;

  vec_t tbl [15];
  int total = 0;
  int bad   = 0;

  function automatic logic [DB-1:0] mk(int b, int tag);
    return {32'(tag), 32'(b), 64'hC0FFEE00_5A5A1234};
  endfunction

  task automatic set_data(int tag);
    for (int b = 0; b < NB; b++)
      in_data[b*DB +: DB] = mk(b, tag);
  endtask

  task automatic chk(string n, logic [DB-1:0] a, logic [DB-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    for (int r = 0; r < 8; r++) begin
      tbl[r].v    = 4'b1111;
      tbl[r].en   = 4'b1111;
      tbl[r].ordy = 1'b1;
      tbl[r].rdy  = 4'(1 << (r % 4));
      tbl[r].ov   = 1'b1;
      tbl[r].src  = 2'(r % 4);
    end
    tbl[8]  = '{4'b0001, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[9]  = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[10] = '{4'b0010, 4'b1101, 1'b1, 4'b0010, 1'b0, 2'd0};
    tbl[11] = '{4'b0010, 4'b1101, 1'b1, 4'b0010, 1'b0, 2'd0};
    tbl[12] = '{4'b0010, 4'b1101, 1'b1, 4'b0010, 1'b0, 2'd0};
    tbl[13] = '{4'b0011, 4'b1101, 1'b1, 4'b0011, 1'b1, 2'd0};
    tbl[14] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};

    rst        = 1'b1;
    in_valid   = '0;
    blk_stall  = '0;
    blk_enable = 4'b1111;
    out_ready  = 1'b0;
    cnt_sel    = '0;
    cnt_clear  = 1'b0;
    set_data(0);
    #2;
    chk("rst_out_valid", DB'(out_valid), DB'(0));
    chk("rst_out_data", out_data, DB'(0));
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_out_src", DB'(out_src), DB'(0));
    chk("rst_stall_any", DB'(stall_any), DB'(0));
    chk("rst_cnt_acc", DB'(cnt_accepted), DB'(0));
    chk("rst_cnt_drop", DB'(cnt_dropped), DB'(0));

    for (int r = 0; r < 15; r++) begin
      in_valid   = tbl[r].v;
      blk_enable = tbl[r].en;
      out_ready  = tbl[r].ordy;
      set_data(r);
      #1;
      chk($sformatf("vec%0d_in_ready", r), DB'(in_ready), DB'(tbl[r].rdy));
      step();
      chk($sformatf("vec%0d_out_valid", r), DB'(out_valid), DB'(tbl[r].ov));
      if (tbl[r].ov) begin
        chk($sformatf("vec%0d_out_src", r), DB'(out_src), DB'(tbl[r].src));
        chk($sformatf("vec%0d_out_data", r), out_data, mk(int'(tbl[r].src), r));
      end
    end

    cnt_sel = 2'd0;
    #1;
    chk("cnt_acc0", DB'(cnt_accepted), DB'(4));
    cnt_sel = 2'd1;
    #1;
    chk("cnt_acc1", DB'(cnt_accepted), DB'(2));
    chk("cnt_drop1", DB'(cnt_dropped), DB'(4));
    cnt_sel = 2'd3;
    #1;
    chk("cnt_acc3", DB'(cnt_accepted), DB'(2));

    // Backpressure: slot holds B while blocks 1,2 wait.
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    set_data(100);
    #1;
    chk("bp_load_rdy", DB'(in_ready), DB'(4'b0001));
    step();
    chk("bp_load_data", out_data, mk(0, 100));
    in_valid = 4'b0110;
    set_data(101);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_hold%0d_rdy", c), DB'(in_ready), DB'(0));
      step();
      chk($sformatf("bp_hold%0d_ov", c), DB'(out_valid), DB'(1));
      chk($sformatf("bp_hold%0d_data", c), out_data, mk(0, 100));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel1_rdy", DB'(in_ready), DB'(4'b0010));
    step();
    chk("bp_rel1_src", DB'(out_src), DB'(1));
    chk("bp_rel1_data", out_data, mk(1, 101));
    in_valid = 4'b0100;
    #1;
    chk("bp_rel2_rdy", DB'(in_ready), DB'(4'b0100));
    step();
    chk("bp_rel2_src", DB'(out_src), DB'(2));
    chk("bp_rel2_data", out_data, mk(2, 101));
    in_valid = 4'b0000;
    step();
    chk("bp_drain_ov", DB'(out_valid), DB'(0));

    // Saturation and clear priority.
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    cnt_sel   = 2'd2;
    #1;
    chk("clr_acc2", DB'(cnt_accepted), DB'(0));
    cnt_sel = 2'd1;
    #1;
    chk("clr_drop1", DB'(cnt_dropped), DB'(0));
    cnt_sel  = 2'd2;
    in_valid = 4'b0100;
    for (int c = 0; c < 9; c++)
      step();
    in_valid = 4'b0000;
    #1;
    chk("sat_acc2_wide", DB'(cnt_accepted), DB'(9));
    chk("sat_acc2_narrow", DB'(s_cnt_acc), DB'(7));
    in_valid  = 4'b0100;
    cnt_clear = 1'b1;
    step();
    in_valid  = 4'b0000;
    cnt_clear = 1'b0;
    #1;
    chk("clr_win_wide", DB'(cnt_accepted), DB'(0));
    chk("clr_win_narrow", DB'(s_cnt_acc), DB'(0));
    step();

    // Stall OR: one cycle of latency, one cycle wide.
    blk_stall = 4'b0100;
    #1;
    chk("stall_pre", DB'(stall_any), DB'(0));
    step();
    chk("stall_on", DB'(stall_any), DB'(1));
    blk_stall = 4'b0000;
    step();
    chk("stall_off", DB'(stall_any), DB'(0));

    // Reset while the slot is full; pointer must return to N-1.
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    set_data(200);
    step();
    chk("mid_load_ov", DB'(out_valid), DB'(1));
    in_valid = 4'b1111;
    #1;
    chk("mid_full_rdy", DB'(in_ready), DB'(0));
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", DB'(out_valid), DB'(0));
    chk("mid_rst_data", out_data, DB'(0));
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_rdy", DB'(in_ready), DB'(4'b0001));
    step();
    chk("post_rst_src", DB'(out_src), DB'(0));
    chk("post_rst_data", out_data, mk(0, 200));
    in_valid = 4'b0000;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
